// File: rtl/keypad_word_entry.sv
`timescale 1ns/1ps
// keypad_word_entry
// Scans a 4x4 active-low hex keypad, debounces press and release, and shifts
// each accepted digit into a 16-bit entry word (newest digit in bits [3:0]).
// Handshake: key_valid is a one-cycle strobe with no ready; key_code and word
// are valid in the cycle key_valid is high and hold until the next accept
// (word may also be zeroed by clear).
module keypad_word_entry #(
   parameter int SCAN_DIV = 64,
   parameter int DEBOUNCE = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  row_n,
   input  logic        clear,
   output logic [3:0]  col_n,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic [15:0] word,
   output logic [1:0]  state_dbg
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE - 1);

   typedef enum logic [1:0] {
      ST_SCAN    = 2'd0,
      ST_CONFIRM = 2'd1,
      ST_HELD    = 2'd2
   } state_t;

   state_t        state, state_nx;
   logic [3:0]    sync1, rs;
   logic [1:0]    col, col_nx;
   logic [SW-1:0] slot, slot_nx;
   logic [DW-1:0] deb, deb_nx;
   logic [3:0]    row_lat, row_lat_nx;
   logic          accept;
   logic          single_hit;
   logic [1:0]    row_idx;
   logic [3:0]    digit;
   logic [3:0]    col_dec;

   // two-flop synchroniser for the asynchronous row returns (idle high)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 4'hF;
         rs    <= 4'hF;
      end else begin
         sync1 <= row_n;
         rs    <= sync1;
      end
   end

   // exactly one low row bit; anything else is idle or ghosting
   always_comb begin
      single_hit = 1'b0;
      case (rs)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: single_hit = 1'b1;
         default: single_hit = 1'b0;
      endcase
   end

   // latched row pattern to row index
   always_comb begin
      row_idx = 2'd0;
      case (row_lat)
         4'b1101: row_idx = 2'd1;
         4'b1011: row_idx = 2'd2;
         4'b0111: row_idx = 2'd3;
         default: row_idx = 2'd0;
      endcase
   end

   // key map lookup from (row, column) to hex digit
   always_comb begin
      digit = 4'h0;
      case ({row_idx, col})
         4'b00_00: digit = 4'h1;
         4'b00_01: digit = 4'h2;
         4'b00_10: digit = 4'h3;
         4'b00_11: digit = 4'hA;
         4'b01_00: digit = 4'h4;
         4'b01_01: digit = 4'h5;
         4'b01_10: digit = 4'h6;
         4'b01_11: digit = 4'hB;
         4'b10_00: digit = 4'h7;
         4'b10_01: digit = 4'h8;
         4'b10_10: digit = 4'h9;
         4'b10_11: digit = 4'hC;
         4'b11_00: digit = 4'hE;
         4'b11_01: digit = 4'h0;
         4'b11_10: digit = 4'hF;
         default:  digit = 4'hD;
      endcase
   end

   // next-state logic: scan slots, confirm a press, wait for a clean release
   always_comb begin
      state_nx   = state;
      col_nx     = col;
      slot_nx    = slot;
      deb_nx     = deb;
      row_lat_nx = row_lat;
      accept     = 1'b0;
      case (state)
         ST_SCAN: begin
            if (slot == SLOT_LAST) begin
               slot_nx = '0;
               if (single_hit) begin
                  state_nx   = ST_CONFIRM;
                  row_lat_nx = rs;
                  deb_nx     = '0;
               end else begin
                  col_nx = col + 2'd1;
               end
            end else begin
               slot_nx = slot + 1'b1;
            end
         end
         ST_CONFIRM: begin
            if (rs == row_lat) begin
               if (deb == DEB_LAST) begin
                  accept   = 1'b1;
                  state_nx = ST_HELD;
                  deb_nx   = '0;
               end else begin
                  deb_nx = deb + 1'b1;
               end
            end else begin
               state_nx = ST_SCAN;
               col_nx   = col + 2'd1;
               slot_nx  = '0;
               deb_nx   = '0;
            end
         end
         ST_HELD: begin
            if (rs == 4'hF) begin
               if (deb == DEB_LAST) begin
                  state_nx = ST_SCAN;
                  col_nx   = col + 2'd1;
                  slot_nx  = '0;
                  deb_nx   = '0;
               end else begin
                  deb_nx = deb + 1'b1;
               end
            end else begin
               deb_nx = '0;
            end
         end
         default: begin
            state_nx = ST_SCAN;
            slot_nx  = '0;
            deb_nx   = '0;
         end
      endcase
   end

   // column index to active-low one-cold drive pattern
   always_comb begin
      col_dec = 4'b1110;
      case (col_nx)
         2'd1:    col_dec = 4'b1101;
         2'd2:    col_dec = 4'b1011;
         2'd3:    col_dec = 4'b0111;
         default: col_dec = 4'b1110;
      endcase
   end

   // FSM and counter registers; col_n registered alongside the column index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_SCAN;
         col     <= 2'd0;
         slot    <= '0;
         deb     <= '0;
         row_lat <= 4'hF;
         col_n   <= 4'b1110;
      end else begin
         state   <= state_nx;
         col     <= col_nx;
         slot    <= slot_nx;
         deb     <= deb_nx;
         row_lat <= row_lat_nx;
         col_n   <= col_dec;
      end
   end

   // keystroke outputs and entry word; accept wins over clear for the new digit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_valid <= 1'b0;
         key_code  <= 4'h0;
         word      <= 16'h0000;
      end else begin
         key_valid <= accept;
         if (accept) begin
            key_code <= digit;
            word     <= clear ? {12'h000, digit} : {word[11:0], digit};
         end else if (clear) begin
            word <= 16'h0000;
         end
      end
   end

   assign state_dbg = state;

endmodule
